// File: rtl/cache_mem_pkg.sv
// Shared types and helpers for the cache data bank.
package cache_mem_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 256;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    RMW_RD = 2'd2,
    RMW_WR = 2'd3
  } state_t;

  // Pick one byte of a read-modify-write merge.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       en);
    return en ? new_byte : old_byte;
  endfunction

  // Even parity bit for one byte (byte plus bit has an even number of ones).
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/cache_mem_array.sv
// Behavioural single-port synchronous RAM, 1-cycle read, contents not reset.
module cache_mem_array #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // One access per cycle: write, or registered read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/cache_mem_bank.sv
// Single-port cache data bank with handshake, byte-enable RMW and post-reset clear.
// Optional per-byte even parity: define CACHE_MEM_PARITY_EN.
module cache_mem_bank
  import cache_mem_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_init_done,
  output logic              o_perr
);

`ifdef CACHE_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + BE_W;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt;
  logic              init_done_q;
  logic              rd_pend_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [BE_W-1:0]   cap_be;

  logic              mem_en, mem_we, rd_issue;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] data_in, merged, dout_data;
  logic [MEM_W-1:0]  mem_din, mem_dout;
  logic              accept;

  assign accept      = i_req_valid & o_req_ready;
  assign o_req_ready = (state_q == IDLE);
  assign o_rvalid    = rd_pend_q;
  assign o_init_done = init_done_q;
  assign dout_data   = mem_dout[DATA_W-1:0];
  // Data is live from the array in the rvalid cycle, then held locally.
  assign o_rdata     = rd_pend_q ? dout_data : rdata_q;

  // Merge captured write bytes over the word read back during RMW_RD.
  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < BE_W; i++)
      merged[i*8 +: 8] = merge_byte(dout_data[i*8 +: 8], cap_wdata[i*8 +: 8], cap_be[i]);
  end

  // Next state and array control.
  always_comb begin
    state_d  = state_q;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = cap_addr;
    data_in  = '0;
    rd_issue = 1'b0;
    case (state_q)
      INIT: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = clr_cnt;
        if (clr_cnt == '1) state_d = IDLE;
      end
      IDLE: begin
        if (accept) begin
          if (!i_write) begin
            mem_en   = 1'b1;
            mem_addr = i_addr;
            rd_issue = 1'b1;
          end else if (&i_be) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = i_addr;
            data_in  = i_wdata;
          end else if (|i_be) begin
            state_d = RMW_RD;
          end
        end
      end
      RMW_RD: begin
        mem_en  = 1'b1;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        mem_en  = 1'b1;
        mem_we  = 1'b1;
        data_in = merged;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

`ifdef CACHE_MEM_PARITY_EN
  logic [BE_W-1:0] par_in, par_chk;

  // Generate stored parity and check parity of the word read back.
  always_comb begin
    par_in  = '0;
    par_chk = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      par_in[i]  = byte_parity(data_in[i*8 +: 8]);
      par_chk[i] = byte_parity(dout_data[i*8 +: 8]) ^ mem_dout[DATA_W + i];
    end
  end

  assign mem_din = {par_in, data_in};
  // RMW_WR is the cycle in which the RMW read word is on the array output.
  assign o_perr  = (rd_pend_q | (state_q == RMW_WR)) & (|par_chk);
`else
  assign mem_din = data_in;
  assign o_perr  = 1'b0;
`endif

  // State, clear counter, read-valid and held read data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= INIT;
      clr_cnt     <= '0;
      init_done_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_issue;
      if (state_q == INIT) clr_cnt <= clr_cnt + 1'b1;
      if (state_q == INIT && clr_cnt == '1) init_done_q <= 1'b1;
      if (rd_pend_q) rdata_q <= dout_data;
    end
  end

  // Request capture for the RMW sequence.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      cap_addr  <= i_addr;
      cap_wdata <= i_wdata;
      cap_be    <= i_be;
    end
  end

  cache_mem_array #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (i_clk),
    .en   (mem_en),
    .we   (mem_we),
    .addr (mem_addr),
    .din  (mem_din),
    .dout (mem_dout)
  );

endmodule

// File: tb/tb_cache_mem_bank.sv
// Self-checking bench for cache_mem_bank (DATA_W=32, DEPTH=256).
module tb_cache_mem_bank;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_write;
  logic [7:0]  i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_be;
  logic        o_rvalid;
  logic [31:0] o_rdata;
  logic        o_init_done;
  logic        o_perr;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] last_rdata;

  cache_mem_bank #(.DATA_W(32), .DEPTH(256)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_write     (i_write),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_be        (i_be),
    .o_rvalid    (o_rvalid),
    .o_rdata     (o_rdata),
    .o_init_done (o_init_done),
    .o_perr      (o_perr)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_clear();
    for (int a = 0; a < 256; a++) ref_mem[a] = 32'h0;
    last_rdata = 32'h0;
  endtask

  // Wait for the clear to finish; it must take exactly DEPTH cycles.
  task automatic wait_init();
    int n = 0;
    check("init_done_low", {31'b0, o_init_done}, 32'd0);
    while (!o_req_ready && n < 1000) begin
      tick();
      n++;
    end
    check("init_cycles", n, 32'd256);
    check("init_done_high", {31'b0, o_init_done}, 32'd1);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp, input logic exp_perr);
    i_req_valid = 1'b1;
    i_write     = 1'b0;
    i_addr      = a;
    i_wdata     = $urandom;
    i_be        = 4'($urandom);
    check("rd_ready", {31'b0, o_req_ready}, 32'd1);
    tick();
    i_req_valid = 1'b0;
    i_addr      = 8'($urandom);
    check("rd_rvalid", {31'b0, o_rvalid}, 32'd1);
    check("rd_data", o_rdata, exp);
    check("rd_perr", {31'b0, o_perr}, {31'b0, exp_perr});
    last_rdata = exp;
    tick();
    check("rd_pulse_end", {31'b0, o_rvalid}, 32'd0);
    check("rd_hold", o_rdata, last_rdata);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] mask;
    logic        partial;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    partial = (be != 4'h0) && (be != 4'hF);
    i_req_valid = 1'b1;
    i_write     = 1'b1;
    i_addr      = a;
    i_wdata     = d;
    i_be        = be;
    check("wr_ready", {31'b0, o_req_ready}, 32'd1);
    tick();
    i_req_valid = 1'b0;
    i_addr      = 8'($urandom);
    i_wdata     = $urandom;
    i_be        = 4'($urandom);
    ref_mem[a] = (ref_mem[a] & ~mask) | (d & mask);
    check("wr_no_rvalid", {31'b0, o_rvalid}, 32'd0);
    if (partial) begin
      check("rmw_busy1", {31'b0, o_req_ready}, 32'd0);
      tick();
      check("rmw_busy2", {31'b0, o_req_ready}, 32'd0);
      check("rmw_no_rvalid", {31'b0, o_rvalid}, 32'd0);
      check("rmw_hold", o_rdata, last_rdata);
      tick();
    end
    check("wr_ready_after", {31'b0, o_req_ready}, 32'd1);
    check("wr_hold", o_rdata, last_rdata);
  endtask

  initial begin
    i_reset     = 1'b1;
    i_req_valid = 1'b0;
    i_write     = 1'b0;
    i_addr      = '0;
    i_wdata     = '0;
    i_be        = '0;
    model_clear();
    tick();
    check("rst_ready", {31'b0, o_req_ready}, 32'd0);
    check("rst_rvalid", {31'b0, o_rvalid}, 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_perr", {31'b0, o_perr}, 32'd0);
    tick();
    i_reset = 1'b0;
    i_req_valid = 1'b1;  // requests while clearing must be ignored
    wait_init();
    i_req_valid = 1'b0;

    // Back-to-back reads of every address after the clear.
    for (int a = 0; a < 256; a++) begin
      i_req_valid = 1'b1;
      i_write     = 1'b0;
      i_addr      = 8'(a);
      check("sweep_ready", {31'b0, o_req_ready}, 32'd1);
      tick();
      check("sweep_rvalid", {31'b0, o_rvalid}, 32'd1);
      check("sweep_data", o_rdata, 32'h0);
    end
    i_req_valid = 1'b0;
    tick();
    check("sweep_rvalid_end", {31'b0, o_rvalid}, 32'd0);

    // Full write then read-after-write.
    do_write(8'h10, 32'hDEADBEEF, 4'hF);
    do_read(8'h10, 32'hDEADBEEF, 1'b0);

    // Partial write merges with existing contents.
    do_write(8'h20, 32'h11223344, 4'hF);
    do_write(8'h20, 32'hAABBCCDD, 4'b0101);
    do_read(8'h20, 32'h11BB33DD, 1'b0);

    // Zero byte-enable write leaves the word untouched.
    do_write(8'h30, 32'h55555555, 4'hF);
    do_write(8'h30, 32'hFFFFFFFF, 4'h0);
    do_read(8'h30, 32'h55555555, 1'b0);

    // Boundary addresses.
    do_write(8'h00, 32'hA5A5_0001, 4'hF);
    do_write(8'hFF, 32'h5A5A_00FF, 4'hF);
    do_read(8'h00, 32'hA5A5_0001, 1'b0);
    do_read(8'hFF, 32'h5A5A_00FF, 1'b0);

    // Randomized traffic against the reference array.
    for (int n = 0; n < 300; n++) begin
      logic [7:0]  a;
      logic [3:0]  be;
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      be = 4'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, be);
      else                           do_read(a, ref_mem[a], 1'b0);
    end

    // Reset in the middle of a partial write.
    do_write(8'h50, 32'h01020304, 4'hF);
    i_req_valid = 1'b1;
    i_write     = 1'b1;
    i_addr      = 8'h50;
    i_wdata     = 32'hFFFFFFFF;
    i_be        = 4'b0011;
    tick();
    i_req_valid = 1'b0;
    check("mid_rmw_busy", {31'b0, o_req_ready}, 32'd0);
    i_reset = 1'b1;
    #1;
    check("mid_rst_rvalid", {31'b0, o_rvalid}, 32'd0);
    check("mid_rst_ready", {31'b0, o_req_ready}, 32'd0);
    check("mid_rst_done", {31'b0, o_init_done}, 32'd0);
    check("mid_rst_rdata", o_rdata, 32'd0);
    model_clear();
    tick();
    i_reset = 1'b0;
    wait_init();
    do_read(8'h50, 32'h0, 1'b0);
    do_read(8'h10, 32'h0, 1'b0);

`ifdef CACHE_MEM_PARITY_EN
    // Stored bit flip is reported with the read, data still returned.
    do_write(8'h40, 32'h0F0F_1234, 4'hF);
    do_write(8'h41, 32'h0F0F_5678, 4'hF);
    dut.u_array.mem[8'h40] = dut.u_array.mem[8'h40] ^ 36'h20;
    do_read(8'h40, 32'h0F0F_1214, 1'b1);
    do_read(8'h41, 32'h0F0F_5678, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_mem_bank.md
Name: cache_mem_bank

Overview:
- Parametrised single-port cache data bank; next generation of the fixed 256x32 cache data memory.
- Adds valid/ready request handshake, per-byte write enables via internal read-modify-write, post-reset clear of all entries, and registered read-valid.
- Sits between the LRU cache controller and the storage array; one bank instance per way.

Parameters:
- DATA_W, 32, data word width in bits; multiple of 8.
- DEPTH, 256, number of words; power of two, >= 4.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- BE_W, DATA_W/8, byte-enable width; derived.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  bank accepts request this cycle.
- i_write  input  1  1 = write, 0 = read; sampled on accept.
- i_addr  input  ADDR_W  word address; sampled on accept.
- i_wdata  input  DATA_W  write data; sampled on accept.
- i_be  input  BE_W  byte enables for writes; ignored on reads.
- o_rvalid  output  1  read data valid, single-cycle pulse.
- o_rdata  output  DATA_W  read data; held until next read completes.
- o_init_done  output  1  post-reset clear finished.
- o_perr  output  1  parity error flag, aligned with o_rvalid.

Behaviour:
- Reset values: o_req_ready=0, o_rvalid=0, o_rdata=0, o_init_done=0, o_perr=0, state=INIT, clear counter=0.
- Accept = i_req_valid & o_req_ready. Request fields are captured only on accept; requester may change them otherwise.
- State machine: INIT, IDLE, RMW_RD, RMW_WR.
- INIT: writes zero to address = counter, counter+1 each cycle; after address DEPTH-1 is written (DEPTH cycles) -> IDLE, o_init_done=1 from the next cycle and stays 1 until reset. o_req_ready=0 throughout.
- IDLE: o_req_ready=1.
  - Read accept: array read; o_rvalid=1 and o_rdata valid exactly 1 cycle after accept. Back-to-back reads are accepted every cycle.
  - Write with i_be all ones: single-cycle array write; stay IDLE; next request accepted the following cycle.
  - Write with i_be all zeros: accepted, no array access, stay IDLE.
  - Partial i_be: -> RMW_RD (array read of captured address), -> RMW_WR (merge: enabled bytes from captured data, others from read word; array write), -> IDLE. o_req_ready=0 in RMW_RD and RMW_WR. A partial write therefore blocks for 2 cycles after accept.
- o_rvalid is never asserted for writes or RMW internal reads.
- Read immediately after write to the same address returns the new data; ordering is guaranteed by the single-port serialisation.
- One array access per cycle maximum; array read latency is 1 cycle.
- Reset asserted in any state: immediate return to INIT with reset values; an in-flight RMW is abandoned, a pending o_rvalid is dropped, and the clear restarts from address 0.
- Address wrap: none; all ADDR_W values are legal.

Optional Feature:
- CACHE_MEM_PARITY_EN defined: array stores DATA_W+BE_W bits with even parity per byte. Writes, INIT and RMW merges generate parity. A read checks it: o_perr=1 in the o_rvalid cycle on any byte mismatch, and o_rdata is still returned. An RMW read with a mismatch also pulses o_perr, without o_rvalid.
- Not defined: array is DATA_W wide and o_perr is tied 0.

Decomposition:
- Package cache_mem_pkg holds: state enum type (INIT, IDLE, RMW_RD, RMW_WR), function for the byte-merge, function for per-byte parity, and default DATA_W/DEPTH constants.
- Sub-module cache_mem_array: behavioural single-port synchronous RAM (en, we, addr, din, dout, 1-cycle read, no reset on contents), width parameterised for the parity option.

Test Plan:
- Reset release, DATA_W=32, DEPTH=256 -> o_req_ready=0 for 256 cycles, o_init_done=1 after; read every address -> 0x0000_0000, o_rvalid one cycle after each accept.
- Full write addr 0x10 data 0xDEADBEEF, be=4'hF, then read 0x10 next cycle -> o_rdata=0xDEADBEEF, ready never drops.
- Preload 0x11223344 at 0x20; partial write data 0xAABBCCDD be=4'b0101 -> ready low 2 cycles; read -> 0x11BB33DD.
- Write be=4'h0 to 0x30 holding 0x55555555 -> accepted in 1 cycle, read still 0x55555555.
- Assert i_reset during RMW_RD of a partial write -> o_rvalid stays 0, INIT restarts at address 0, target word reads 0 after o_init_done.
- With CACHE_MEM_PARITY_EN: force one stored bit flip at 0x40, read 0x40 -> o_perr=1 with o_rvalid; unflipped address -> o_perr=0.
